// File: rtl/core_run_controller.sv
// Run/reset sequencer: holds the core in reset, runs it, drains on halt, stops on timeout.
// Optional PC-stall halt detection is built when RUNCTL_STALL_DETECT_EN is defined.
module core_run_controller #(
   parameter int CNT_W        = 32,
   parameter int RESET_CYCLES = 4,
   parameter int MAX_CYCLES   = 1000,
   parameter int DRAIN_CYCLES = 4,
   parameter int XLEN         = 32,
   parameter int STALL_LIMIT  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             halt_i,
   input  logic [XLEN-1:0]  pc_i,
   output logic             core_reset,
   output logic             core_run,
   output logic [CNT_W-1:0] cycle_count,
   output logic             done,
   output logic             timed_out,
   output logic             stall_halt,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      S_HOLD  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [HW-1:0]    HOLD_LAST  = HW'(RESET_CYCLES - 1);
   localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] MAX_M1     = CNT_W'(MAX_CYCLES - 1);

   state_e           state_q, state_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [DW-1:0]    drain_q, drain_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             to_q, to_d;
   logic             sh_q, sh_d;
   logic             stall_hit;
   logic             eff_halt;

`ifdef RUNCTL_STALL_DETECT_EN
   localparam int SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
   localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [SW-1:0]   stall_q, stall_d;
   logic            pc_same;

   assign pc_same   = (pc_i == pc_q);
   assign stall_hit = (state_q == S_RUN) && pc_same
                      && (stall_q == STALL_LAST);

   always_comb begin
      pc_d    = pc_q;
      stall_d = stall_q;
      if (state_q == S_RUN) begin
         pc_d    = pc_i;
         stall_d = pc_same ? stall_q + SW'(1) : '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= '0;
         stall_q <= '0;
      end else begin
         pc_q    <= pc_d;
         stall_q <= stall_d;
      end
   end
`else
   logic unused_pc;

   assign unused_pc = ^pc_i;
   assign stall_hit = 1'b0;
`endif

   // saturate rather than wrap so a runaway run stays visibly maxed out
   assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
   assign eff_halt = halt_i | stall_hit;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      drain_d = drain_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      sh_d    = sh_q;
      unique case (state_q)
         S_HOLD: begin
            if (hold_q == HOLD_LAST) state_d = S_RUN;
            else hold_d = hold_q + HW'(1);
         end
         S_RUN: begin
            cnt_d = cnt_inc;
            if (eff_halt) begin
               sh_d    = sh_q | stall_hit;
               drain_d = '0;
               state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
            end else if (MAX_CYCLES != 0 && cnt_q == MAX_M1) begin
               state_d = S_DONE;
               to_d    = 1'b1;
            end
         end
         S_DRAIN: begin
            cnt_d = cnt_inc;
            if (drain_q == DRAIN_LAST) state_d = S_DONE;
            else drain_d = drain_q + DW'(1);
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: state_d = S_HOLD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_HOLD;
         hold_q  <= '0;
         drain_q <= '0;
         cnt_q   <= '0;
         to_q    <= 1'b0;
         sh_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         drain_q <= drain_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
         sh_q    <= sh_d;
      end
   end

   assign core_reset  = (state_q == S_HOLD);
   assign core_run    = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done        = (state_q == S_DONE);
   assign cycle_count = cnt_q;
   assign timed_out   = to_q;
   assign stall_halt  = sh_q;
   assign state_o     = state_q;

endmodule
